// File: rtl/dda_lorenz_seq.sv
// Time-multiplexed forward-Euler Lorenz integrator: one shared multiplier, 8-cycle step, decimated valid.
// Define DDA_SAT_EN for saturating arithmetic with a sticky ovf flag; otherwise results wrap and ovf stays 0.
module dda_lorenz_seq #(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int DECIM = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic signed [W-1:0] icx,
  input  logic signed [W-1:0] icy,
  input  logic signed [W-1:0] icz,
  input  logic signed [W-1:0] sigma,
  input  logic signed [W-1:0] beta,
  input  logic signed [W-1:0] rho,
  input  logic signed [W-1:0] dt,
  output logic signed [W-1:0] x,
  output logic signed [W-1:0] y,
  output logic signed [W-1:0] z,
  output logic                valid,
  output logic                busy,
  output logic                ovf
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;

  state_t              state;
  logic [2:0]          phase;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] sh_sigma, sh_beta, sh_rho, sh_dt;
  logic signed [W-1:0] a_r, b_r, c_r, d_r;

`ifdef DDA_SAT_EN
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] add_n(input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] q,
                                                 input logic neg, output logic clip);
    logic signed [W:0] s;
    s = neg ? ({p[W-1], p} - {q[W-1], q}) : ({p[W-1], p} + {q[W-1], q});
    clip = (s[W] != s[W-1]);
    add_n = clip ? (s[W] ? SMIN : SMAX) : s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] mul_n(input logic signed [2*W-1:0] p,
                                                 output logic clip);
    logic signed [2*W-1:0] sh;
    sh = p >>> FRAC;
    clip = (sh[2*W-1:W-1] != '0) && (sh[2*W-1:W-1] != '1);
    mul_n = clip ? (sh[2*W-1] ? SMIN : SMAX) : sh[W-1:0];
  endfunction
`else
  function automatic logic signed [W-1:0] add_n(input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] q,
                                                 input logic neg, output logic clip);
    clip = 1'b0;
    add_n = neg ? (p - q) : (p + q);
  endfunction

  function automatic logic signed [W-1:0] mul_n(input logic signed [2*W-1:0] p,
                                                 output logic clip);
    clip = 1'b0;
    mul_n = W'(p >>> FRAC);
  endfunction
`endif

  logic signed [W-1:0]   op_a, op_b, mul_res, nx, ny, nz;
  logic signed [2*W-1:0] prod;
  logic                  sub_clip, mul_clip, clip_calc, cx, cy, cz, clip_upd;

  // Operand mux for the single multiplier; phases 4-6 reuse a_r/b_r/c_r for the deltas.
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    sub_clip = 1'b0;
    case (phase)
      3'd0: begin op_a = sh_sigma; op_b = add_n(y, x, 1'b1, sub_clip);       end
      3'd1: begin op_a = x;        op_b = add_n(sh_rho, z, 1'b1, sub_clip);  end
      3'd2: begin op_a = x;        op_b = y;                                 end
      3'd3: begin op_a = sh_beta;  op_b = z;                                 end
      3'd4: begin op_a = sh_dt;    op_b = a_r;                               end
      3'd5: begin op_a = sh_dt;    op_b = add_n(b_r, y, 1'b1, sub_clip);     end
      3'd6: begin op_a = sh_dt;    op_b = add_n(c_r, d_r, 1'b1, sub_clip);   end
      default: ;
    endcase
    prod      = op_a * op_b;
    mul_res   = mul_n(prod, mul_clip);
    clip_calc = sub_clip | mul_clip;
  end

  always_comb begin
    nx       = add_n(x, a_r, 1'b0, cx);
    ny       = add_n(y, b_r, 1'b0, cy);
    nz       = add_n(z, c_r, 1'b0, cz);
    clip_upd = cx | cy | cz;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      sh_sigma <= '0;
      sh_beta  <= '0;
      sh_rho   <= '0;
      sh_dt    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      d_r      <= '0;
    end else if (load) begin
      x     <= icx;
      y     <= icy;
      z     <= icz;
      state <= IDLE;
      phase <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            sh_sigma <= sigma;
            sh_beta  <= beta;
            sh_rho   <= rho;
            sh_dt    <= dt;
            phase    <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          case (phase)
            3'd0, 3'd4: a_r <= mul_res;
            3'd1, 3'd5: b_r <= mul_res;
            3'd2, 3'd6: c_r <= mul_res;
            3'd3:       d_r <= mul_res;
            default: ;
          endcase
          ovf <= ovf | clip_calc;
          if (phase == 3'd6) state <= UPDATE;
          else phase <= phase + 3'd1;
        end
        UPDATE: begin
          x   <= nx;
          y   <= ny;
          z   <= nz;
          ovf <= ovf | clip_upd;
          if (cnt == CW'(DECIM - 1)) begin
            cnt   <= '0;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          phase <= '0;
          if (en) begin
            sh_sigma <= sigma;
            sh_beta  <= beta;
            sh_rho   <= rho;
            sh_dt    <= dt;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_lorenz_seq.sv
// Scoreboard bench for dda_lorenz_seq: DECIM=1 instance for stepping/abort/saturation, DECIM=4 instance for decimation.
module tb_dda_lorenz_seq;

  logic clk = 1'b0;
  logic rst, en, load, en2, load2;
  logic [15:0] icx, icy, icz, sigma, beta, rho, dt;
  logic [15:0] x, y, z, x2, y2, z2;
  logic valid, busy, ovf, valid2, busy2, ovf2;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] x, y, z;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dda_lorenz_seq #(.W(16), .FRAC(8), .DECIM(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .icx(icx), .icy(icy), .icz(icz),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .x(x), .y(y), .z(z), .valid(valid), .busy(busy), .ovf(ovf)
  );

  dda_lorenz_seq #(.W(16), .FRAC(8), .DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .en(en2), .load(load2),
    .icx(icx), .icy(icy), .icz(icz),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .x(x2), .y(y2), .z(z2), .valid(valid2), .busy(busy2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop the expected sample whenever a valid pulse appears.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid dut: got valid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut x", {16'h0, x}, {16'h0, e.x});
        chk("dut y", {16'h0, y}, {16'h0, e.y});
        chk("dut z", {16'h0, z}, {16'h0, e.z});
        chk("dut ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("dut valid_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid2) begin
      if (q2.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid dut4: got valid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut4 x", {16'h0, x2}, {16'h0, e.x});
        chk("dut4 y", {16'h0, y2}, {16'h0, e.y});
        chk("dut4 z", {16'h0, z2}, {16'h0, e.z});
        chk("dut4 ovf", {31'h0, ovf2}, {31'h0, e.ovf});
        chk("dut4 valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input logic [15:0] s, input logic [15:0] r,
                          input logic [15:0] b, input logic [15:0] d);
    sigma = s; rho = r; beta = b; dt = d;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    icx = a; icy = b; icz = c;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic push1(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                       input logic eo, input int ec);
    exp_t e;
    e.x = ex; e.y = ey; e.z = ez; e.ovf = eo; e.cyc = ec;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                       input logic eo, input int ec);
    exp_t e;
    e.x = ex; e.y = ey; e.z = ez; e.ovf = eo; e.cyc = ec;
    q2.push_back(e);
  endtask

  // One step of the DECIM=1 instance with en pulsed for a single cycle.
  task automatic one_step(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                          input logic eo);
    int k;
    en = 1'b1;
    tick(1);
    k = cyc;
    en = 1'b0;
    push1(ex, ey, ez, eo, k + 8);
    tick(3);
    chk("busy_mid_step", {31'h0, busy}, 32'h1);
    tick(5);
    chk("busy_after_step", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; load = 1'b0; en2 = 1'b0; load2 = 1'b0;
    icx = '0; icy = '0; icz = '0;
    set_coef(16'h0, 16'h0, 16'h0, 16'h0);
    tick(2);
    chk("reset x", {16'h0, x}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset valid", {31'h0, valid}, 32'h0);
    chk("reset ovf", {31'h0, ovf}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Single step from (1,0,0) with sigma=10, rho=28, beta=8/3, dt=1/256.
    set_coef(16'h0A00, 16'h1C00, 16'h02AB, 16'h0001);
    do_load(16'h0100, 16'h0000, 16'h0000);
    chk("load x", {16'h0, x}, 32'h0100);
    one_step(16'h00F6, 16'h001C, 16'h0000, 1'b0);
    tick(2);

    // en dropped two cycles into a step: step completes, then state holds.
    do_load(16'h0100, 16'h0000, 16'h0000);
    en = 1'b1;
    tick(1);
    k = cyc;
    push1(16'h00F6, 16'h001C, 16'h0000, 1'b0, k + 8);
    tick(2);
    en = 1'b0;
    tick(6);
    chk("en_drop busy", {31'h0, busy}, 32'h0);
    tick(5);
    chk("en_drop hold x", {16'h0, x}, 32'h00F6);
    chk("en_drop hold y", {16'h0, y}, 32'h001C);

    // Abort by load mid-step: no pulse, ICs taken, then restart.
    do_load(16'h0100, 16'h0000, 16'h0000);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(2);
    do_load(16'h0200, 16'h0300, 16'h0400);
    chk("abort x", {16'h0, x}, 32'h0200);
    chk("abort y", {16'h0, y}, 32'h0300);
    chk("abort z", {16'h0, z}, 32'h0400);
    chk("abort busy", {31'h0, busy}, 32'h0);
    tick(10);
    do_load(16'h0100, 16'h0000, 16'h0000);
    one_step(16'h00F6, 16'h001C, 16'h0000, 1'b0);
    tick(2);

    // Asynchronous reset in the middle of a step.
    do_load(16'h0100, 16'h0000, 16'h0000);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst x", {16'h0, x}, 32'h0);
    chk("async_rst busy", {31'h0, busy}, 32'h0);
    chk("async_rst valid", {31'h0, valid}, 32'h0);
    chk("async_rst ovf", {31'h0, ovf}, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Overflow corner: products and sums leave the Q8.8 range.
    set_coef(16'h0000, 16'h0000, 16'h0000, 16'h0100);
    do_load(16'h7000, 16'h7000, 16'h7000);
`ifdef DDA_SAT_EN
    one_step(16'h7000, 16'hF000, 16'h7FFF, 1'b1);
    tick(5);
    chk("ovf sticky", {31'h0, ovf}, 32'h1);
`else
    one_step(16'h7000, 16'h0000, 16'h7000, 1'b0);
    tick(5);
    chk("ovf stays low", {31'h0, ovf}, 32'h0);
`endif
    do_load(16'h0100, 16'h0000, 16'h0000);
    chk("ovf after load", {31'h0, ovf}, 32'h0);

    // Decimation by 4 with en held: (1,0,0), sigma=0, rho=2, beta=0, dt=1.
    set_coef(16'h0000, 16'h0200, 16'h0000, 16'h0100);
    icx = 16'h0100; icy = 16'h0000; icz = 16'h0000;
    load2 = 1'b1;
    tick(1);
    load2 = 1'b0;
    en2 = 1'b1;
    tick(1);
    k = cyc;
    push2(16'h0100, 16'hFE00, 16'h0400, 1'b0, k + 32);
    push2(16'h0100, 16'h0200, 16'h0200, 1'b0, k + 64);
    tick(8);
    chk("decim step1 y", {16'h0, y2}, 32'h0200);
    chk("decim step1 z", {16'h0, z2}, 32'h0000);
    tick(8);
    chk("decim step2 z", {16'h0, z2}, 32'h0200);
    tick(8);
    chk("decim step3 y", {16'h0, y2}, 32'h0000);
    chk("decim step3 z", {16'h0, z2}, 32'h0400);
    tick(36);
    en2 = 1'b0;
    tick(14);
    chk("decim busy idle", {31'h0, busy2}, 32'h0);

    tick(4);
    while (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_valid dut: got no pulse expected valid at cycle %0d", e.cyc);
    end
    while (q2.size() > 0) begin
      exp_t e;
      e = q2.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_valid dut4: got no pulse expected valid at cycle %0d", e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
